// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient path.
// Loader states and the coefficient word type.
package fir_pkg;

  localparam int COEFF_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } loader_state_t;

  typedef logic signed [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register bank: clear-all, indexed write,
// parallel load and a flattened read port (entry 0 in the LSBs).
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = $bits(coeff_t),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [W-1:0]       wdata_i,
  input  logic               ld_i,
  input  logic [DEPTH*W-1:0] ld_data_i,
  output logic [DEPTH*W-1:0] rd_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      mem_q <= '0;
    end else if (ld_i) begin
      mem_q <= ld_data_i;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_o = mem_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Collects a coefficient set into a shadow bank and swaps it
// into the active bank on a sample boundary.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int MAX_TAPS  = 16,
  parameter int COEFF_W   = fir_pkg::COEFF_W,
  parameter int TAP_CNT_W = $clog2(MAX_TAPS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic [TAP_CNT_W-1:0]        num_taps,
  input  logic                        coeff_data_valid,
  input  logic [31:0]                 coeff_data,
  input  logic                        sample_strobe,
  output logic [MAX_TAPS*COEFF_W-1:0] coeffs,
  output logic [TAP_CNT_W-1:0]        num_taps_active,
  output logic                        busy,
  output logic                        swap_done,
  output logic                        load_error
);

  localparam int AW = $clog2(MAX_TAPS);

  loader_state_t        state_q, state_d;
  logic [TAP_CNT_W-1:0] idx_q, idx_d;
  logic [TAP_CNT_W-1:0] ntaps_q, ntaps_d;
  logic [TAP_CNT_W-1:0] nact_q, nact_d;
  logic                 err_q, err_d;
  logic                 swap_q, swap_d;

  logic sh_clr, sh_we, act_ld, cnt_ok, word_in;
  logic [MAX_TAPS*COEFF_W-1:0] sh_rd;
  logic unused_hi;

  assign unused_hi = ^coeff_data[31:COEFF_W];
  assign cnt_ok    = (num_taps != '0) &&
                     (num_taps <= TAP_CNT_W'(MAX_TAPS));
  // load_start always wins over a coincident word
  assign word_in   = coeff_data_valid && !load_start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ntaps_d = ntaps_q;
    nact_d  = nact_q;
    err_d   = err_q;
    swap_d  = 1'b0;
    sh_clr  = 1'b0;
    sh_we   = 1'b0;
    act_ld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (word_in) err_d = 1'b1;
      end
      LOAD: begin
        if (word_in) begin
          sh_we = 1'b1;
          idx_d = idx_q + TAP_CNT_W'(1);
          if (idx_q == ntaps_q - TAP_CNT_W'(1))
            state_d = PENDING;
        end
      end
      PENDING: begin
        if (sample_strobe) begin
          act_ld  = 1'b1;
          nact_d  = ntaps_q;
          swap_d  = 1'b1;
          state_d = IDLE;
        end
        if (word_in) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // the swap above reads the old shadow, so clearing here is safe
    if (load_start) begin
      if (cnt_ok) begin
        ntaps_d = num_taps;
        idx_d   = '0;
        err_d   = 1'b0;
        sh_clr  = 1'b1;
        state_d = LOAD;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ntaps_q <= '0;
      nact_q  <= '0;
      err_q   <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ntaps_q <= ntaps_d;
      nact_q  <= nact_d;
      err_q   <= err_d;
      swap_q  <= swap_d;
    end
  end

  fir_coeff_bank #(
    .DEPTH (MAX_TAPS),
    .W     (COEFF_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (sh_clr),
    .we_i      (sh_we),
    .waddr_i   (idx_q[AW-1:0]),
    .wdata_i   (coeff_data[COEFF_W-1:0]),
    .ld_i      (1'b0),
    .ld_data_i ('0),
    .rd_o      (sh_rd)
  );

  fir_coeff_bank #(
    .DEPTH (MAX_TAPS),
    .W     (COEFF_W)
  ) u_active (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (1'b0),
    .we_i      (1'b0),
    .waddr_i   ('0),
    .wdata_i   ('0),
    .ld_i      (act_ld),
    .ld_data_i (sh_rd),
    .rd_o      (coeffs)
  );

  assign num_taps_active = nact_q;
  assign busy            = (state_q != IDLE);
  assign swap_done       = swap_q;
  assign load_error      = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: table vectors, corner sequences
// and random traffic against a behavioural model.
module tb_fir_coeff_loader;

  localparam int MT = 16;
  localparam int CW = 16;
  localparam int TW = 5;
  localparam int FW = MT * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [TW-1:0] num_taps;
  logic          coeff_data_valid;
  logic [31:0]   coeff_data;
  logic          sample_strobe;
  logic [FW-1:0] coeffs;
  logic [TW-1:0] num_taps_active;
  logic          busy;
  logic          swap_done;
  logic          load_error;

  always #5 clk = ~clk;

  fir_coeff_loader dut (
    .clk              (clk),
    .rst              (rst),
    .load_start       (load_start),
    .num_taps         (num_taps),
    .coeff_data_valid (coeff_data_valid),
    .coeff_data       (coeff_data),
    .sample_strobe    (sample_strobe),
    .coeffs           (coeffs),
    .num_taps_active  (num_taps_active),
    .busy             (busy),
    .swap_done        (swap_done),
    .load_error       (load_error)
  );

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model: a set being collected, a set waiting, an active set
  logic [15:0] m_sh [MT];
  logic [15:0] m_act[MT];
  int m_need, m_got, m_nact;
  bit m_collect, m_wait, m_err, m_swap;

  function automatic void model_step(bit r, bit ls, int nt,
                                     bit cdv, logic [31:0] cd,
                                     bit ss);
    if (r) begin
      foreach (m_sh[i]) m_sh[i] = '0;
      foreach (m_act[i]) m_act[i] = '0;
      m_need = 0; m_got = 0; m_nact = 0;
      m_collect = 0; m_wait = 0; m_err = 0; m_swap = 0;
      return;
    end
    m_swap = 0;
    if (m_wait && ss) begin
      m_act  = m_sh;
      m_nact = m_need;
      m_swap = 1;
      m_wait = 0;
    end
    if (ls) begin
      m_collect = 0;
      m_wait    = 0;
      if (nt >= 1 && nt <= MT) begin
        m_need = nt;
        m_got  = 0;
        foreach (m_sh[i]) m_sh[i] = '0;
        m_err     = 0;
        m_collect = 1;
      end else begin
        m_err = 1;
      end
    end else if (cdv) begin
      if (m_collect) begin
        m_sh[m_got] = cd[15:0];
        m_got++;
        if (m_got == m_need) begin
          m_collect = 0;
          m_wait    = 1;
        end
      end else begin
        m_err = 1;
      end
    end
  endfunction

  function automatic logic [FW-1:0] m_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < MT; i++) f[i*CW +: CW] = m_act[i];
    return f;
  endfunction

  task automatic chk(string name, logic [FW-1:0] act,
                     logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(bit r, bit ls, int nt, bit cdv,
                       logic [31:0] cd, bit ss);
    rst              = r;
    load_start       = ls;
    num_taps         = TW'(nt);
    coeff_data_valid = cdv;
    coeff_data       = cd;
    sample_strobe    = ss;
    @(posedge clk);
    model_step(r, ls, nt, cdv, cd, ss);
    #1;
    chk("coeffs", coeffs, m_flat());
    chk("num_taps_active", FW'(num_taps_active), FW'(m_nact));
    chk("busy", FW'(busy), FW'(m_collect | m_wait));
    chk("swap_done", FW'(swap_done), FW'(m_swap));
    chk("load_error", FW'(load_error), FW'(m_err));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit          ls;
    int          nt;
    bit          cdv;
    logic [31:0] cd;
    bit          ss;
    bit          busy;
    bit          swap;
    bit          err;
    int          nta;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 4,  0, 0,     0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0,  1, 'h11,  0, 1, 0, 0, 0};
    tbl[2]  = '{0, 0,  1, 'h22,  0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0,  1, 'h33,  0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0,  1, 'h44,  0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0,  0, 0,     1, 0, 1, 0, 4};
    tbl[6]  = '{0, 0,  0, 0,     0, 0, 0, 0, 4};
    tbl[7]  = '{1, 0,  0, 0,     0, 0, 0, 1, 4};
    tbl[8]  = '{1, 17, 0, 0,     0, 0, 0, 1, 4};
    tbl[9]  = '{0, 0,  1, 'h99,  0, 0, 0, 1, 4};
    tbl[10] = '{1, 1,  0, 0,     0, 1, 0, 0, 4};
    tbl[11] = '{1, 1,  1, 'h77,  0, 1, 0, 0, 4};
    tbl[12] = '{0, 0,  1, 'h55,  0, 1, 0, 0, 4};
    tbl[13] = '{0, 0,  0, 0,     1, 0, 1, 0, 1};

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("reset_coeffs", coeffs, '0);
    chk("reset_busy", FW'(busy), '0);

    for (int i = 0; i < 14; i++) begin
      cycle(0, tbl[i].ls, tbl[i].nt, tbl[i].cdv, tbl[i].cd,
            tbl[i].ss);
      chk($sformatf("tbl%0d_busy", i), FW'(busy), FW'(tbl[i].busy));
      chk($sformatf("tbl%0d_swap", i), FW'(swap_done),
          FW'(tbl[i].swap));
      chk($sformatf("tbl%0d_err", i), FW'(load_error),
          FW'(tbl[i].err));
      chk($sformatf("tbl%0d_nta", i), FW'(num_taps_active),
          FW'(tbl[i].nta));
      if (i == 5 || i == 9)
        chk($sformatf("tbl%0d_coeffs", i), coeffs,
            FW'(64'h0044_0033_0022_0011));
    end
    chk("tbl_final_coeffs", coeffs, FW'(16'h0055));

    // 3-tap set held pending while no sample arrives
    cycle(0, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 1, 'hAAA1, 0);
    cycle(0, 0, 0, 1, 'hAAA2, 0);
    cycle(0, 0, 0, 1, 'hAAA3, 0);
    idle(10);
    chk("hold_busy", FW'(busy), FW'(1));
    chk("hold_coeffs", coeffs, FW'(16'h0055));
    cycle(0, 0, 0, 0, 0, 1);
    chk("hold_swap", coeffs, FW'(48'hAAA3_AAA2_AAA1));
    chk("hold_done", FW'(swap_done), FW'(1));

    // restart mid-load leaves no stale words
    cycle(0, 1, 5, 0, 0, 0);
    cycle(0, 0, 0, 1, 'hE1, 0);
    cycle(0, 0, 0, 1, 'hE2, 0);
    cycle(0, 1, 2, 0, 0, 0);
    cycle(0, 0, 0, 1, 'hA, 0);
    cycle(0, 0, 0, 1, 'hB, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("restart_coeffs", coeffs, FW'(32'h000B_000A));
    chk("restart_nta", FW'(num_taps_active), FW'(2));

    // swap and new load in the same cycle
    cycle(0, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 1, 'h1, 0);
    cycle(0, 0, 0, 1, 'h2, 0);
    cycle(0, 0, 0, 1, 'h3, 0);
    cycle(0, 1, 2, 0, 0, 1);
    chk("both_done", FW'(swap_done), FW'(1));
    chk("both_busy", FW'(busy), FW'(1));
    chk("both_coeffs", coeffs, FW'(48'h0003_0002_0001));
    cycle(0, 0, 0, 1, 'hC, 0);
    cycle(0, 0, 0, 1, 'hD, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("both_next", coeffs, FW'(32'h000D_000C));

    // full 16-tap set, then reset in the middle of the next load
    cycle(0, 1, 16, 0, 0, 0);
    for (int i = 0; i < MT; i++) cycle(0, 0, 0, 1, $urandom, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("full_nta", FW'(num_taps_active), FW'(16));
    cycle(0, 1, 4, 0, 0, 0);
    cycle(0, 0, 0, 1, 'h1234, 0);
    cycle(1, 0, 0, 1, 'h5678, 0);
    chk("rst_coeffs", coeffs, '0);
    chk("rst_nta", FW'(num_taps_active), '0);
    chk("rst_busy", FW'(busy), '0);
    cycle(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      int nt;
      nt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18))
                                       : int'($urandom_range(1, 6));
      cycle($urandom_range(0, 149) == 0,
            $urandom_range(0, 14) == 0, nt,
            $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
